armleocpu_divider: RTL and testbench

//  Iterative 32/32 unsigned divider (restoring, 1 quotient bit/cycle): quotient + remainder.

---
 rtl/armleocpu_divider_if.sv | 23 ++
 rtl/armleocpu_divider.sv | 127 ++++++++++++
 tb/tb_armleocpu_divider.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/armleocpu_divider_if.sv
// Divider request/result bundle.
// Caller drives operands with valid; the divider returns results with ready.
interface armleocpu_divider_if;
  logic        valid;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        division_by_zero;

  modport master (
    output valid, dividend, divisor,
    input  ready, quotient, remainder,
    input  division_by_zero
  );

  modport slave (
    input  valid, dividend, divisor,
    output ready, quotient, remainder,
    output division_by_zero
  );
endinterface

// File: rtl/armleocpu_divider.sv
// Iterative 32/32 unsigned restoring divider, one quotient bit per cycle.
// Define ARMLEOCPU_DIVIDER_EARLY_EXIT_EN to finish dividend<divisor in one cycle.
module armleocpu_divider (
  input  logic                clk,
  input  logic                rst_n,
  armleocpu_divider_if.slave  bus
);

  typedef enum logic {IDLE, OP} state_t;

  state_t      state, state_nxt;
  logic [31:0] q_reg, q_nxt;
  logic [31:0] d_reg, d_nxt;
  logic [31:0] r_reg, r_nxt;
  logic [31:0] quo_q, quo_nxt;
  logic [31:0] rem_q, rem_nxt;
  logic [4:0]  cycle, cycle_nxt;
  logic        ready_q, ready_nxt;
  logic        dbz_q, dbz_nxt;

  logic [32:0] t;
  logic [31:0] q_step, r_step;
  logic        early;

  assign t = {r_reg, q_reg[31]} - {1'b0, d_reg};

  always_comb begin
    if (t[32]) begin
      r_step = {r_reg[30:0], q_reg[31]};
      q_step = {q_reg[30:0], 1'b0};
    end else begin
      r_step = t[31:0];
      q_step = {q_reg[30:0], 1'b1};
    end
  end

`ifdef ARMLEOCPU_DIVIDER_EARLY_EXIT_EN
  // q_reg still holds the raw dividend on the first OP edge
  assign early = (cycle == 5'd0) && (q_reg < d_reg);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      q_reg   <= '0;
      d_reg   <= '0;
      r_reg   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cycle   <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      q_reg   <= q_nxt;
      d_reg   <= d_nxt;
      r_reg   <= r_nxt;
      quo_q   <= quo_nxt;
      rem_q   <= rem_nxt;
      cycle   <= cycle_nxt;
      ready_q <= ready_nxt;
      dbz_q   <= dbz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_reg;
    d_nxt     = d_reg;
    r_nxt     = r_reg;
    quo_nxt   = quo_q;
    rem_nxt   = rem_q;
    cycle_nxt = cycle;
    ready_nxt = 1'b0;
    dbz_nxt   = dbz_q;
    unique case (state)
      IDLE: begin
        if (bus.valid) begin
          q_nxt     = bus.dividend;
          d_nxt     = bus.divisor;
          r_nxt     = '0;
          cycle_nxt = '0;
          dbz_nxt   = 1'b0;
          state_nxt = OP;
        end
      end
      OP: begin
        unique case (1'b1)
          (d_reg == 32'd0): begin
            quo_nxt   = 32'hFFFF_FFFF;
            rem_nxt   = q_reg;
            dbz_nxt   = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end
          early: begin
            quo_nxt   = '0;
            rem_nxt   = q_reg;
            ready_nxt = 1'b1;
            state_nxt = IDLE;
          end
          default: begin
            q_nxt = q_step;
            r_nxt = r_step;
            if (cycle == 5'd31) begin
              quo_nxt   = q_step;
              rem_nxt   = r_step;
              ready_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              cycle_nxt = cycle + 5'd1;
            end
          end
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready            = ready_q;
  assign bus.quotient         = quo_q;
  assign bus.remainder        = rem_q;
  assign bus.division_by_zero = dbz_q;

endmodule

// File: tb/tb_armleocpu_divider.sv
// Self-checking bench for armleocpu_divider: vector table, scoreboard,
// back-to-back, mid-op reset and random sweep.
module tb_armleocpu_divider;

  logic clk;
  logic rst_n;
  armleocpu_divider_if bus ();

  armleocpu_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   passed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic int lat_of(input logic [31:0] a,
                                input logic [31:0] b);
    if (b == 32'd0) return 1;
`ifdef ARMLEOCPU_DIVIDER_EARLY_EXIT_EN
    if (a < b) return 1;
`endif
    return 32;
  endfunction

  // Monitor: every ready pulse must match the oldest expectation
  always @(posedge clk) begin
    #1;
    if (bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("dbz", {31'd0, bus.division_by_zero},
              {31'd0, e.dbz});
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] q, input logic [31:0] r,
                      input logic dbz);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.due = cyc + lat_of(a, b);
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("timeout", sb.size(), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic dbz);
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    push(a, b, q, r, dbz);
    bus.valid    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    wait_done();
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] a, b;
    cyc    = 0;
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus.valid    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
    vecs[3] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};
    vecs[4] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    vecs[5] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    vecs[6] = '{32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0};
    vecs[7] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
    vecs[8] = '{32'd12345, 32'd12345, 32'd1, 32'd0, 1'b0};
    vecs[9] = '{32'd1000, 32'd33, 32'd30, 32'd10, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_quot", bus.quotient, 32'd0);
    check("rst_rem", bus.remainder, 32'd0);
    check("rst_dbz", {31'd0, bus.division_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // valid held high: second request accepted in the ready cycle
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd10;
    @(posedge clk);
    #1;
    push(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
    bus.dividend = 32'd7;
    bus.divisor  = 32'd2;
    repeat (32) @(posedge clk);
    @(posedge clk);
    #1;
    push(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    bus.valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("hold_quot", bus.quotient, 32'd100);
    check("hold_rem", bus.remainder, 32'd0);
    wait_done();

    // reset at OP cycle 10 aborts without a ready pulse
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    check("abort_quot", bus.quotient, 32'd0);
    check("abort_rem", bus.remainder, 32'd0);
    check("abort_dbz", {31'd0, bus.division_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      unique case (k % 5)
        0: a = 32'd0;
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      unique case (k % 4)
        0: b = 32'd1;
        1: b = $urandom_range(1, 20);
        2: b = (k % 8 == 2) ? 32'd0 : $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (b == 32'd0)
        run_op(a, b, 32'hFFFFFFFF, a, 1'b1);
      else
        run_op(a, b, a / b, a % b, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
